// File: rtl/clk_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_divider_multi
// Brief    : NUM_CH independent runtime-programmable toggle dividers, each with
//            a 50%-duty clk_out, a one-cycle tick strobe and glitch-free
//            divisor reload at terminal count. Optional macro CLK_DIV_SYNC_EN
//            adds a sync_i input that phase-aligns every enabled channel.
// Revision : 1.0 - initial release
// ============================================================================
module clk_divider_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 49999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_i,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [WIDTH-1:0] c_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);

    logic w_sync;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            localparam logic [3:0] c_IDX = 4'(g);

            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_active;
            logic [WIDTH-1:0] r_pending;
            logic             r_pend;
            logic             r_clk_out;
            logic             r_tick;

            logic w_wr;
            logic w_tc;
            logic w_apply;

            // Out-of-range channel indices never match, so such writes are dropped.
            assign w_wr    = wr_en && (wr_ch == c_IDX);
            assign w_tc    = en[g] && (r_count == r_active);
            assign w_apply = en[g] && (w_sync || w_tc);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count   <= '0;
                    r_active  <= c_DEFAULT_DIV;
                    r_pending <= c_DEFAULT_DIV;
                    r_pend    <= 1'b0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                end else if (!en[g]) begin
                    r_count   <= '0;
                    r_tick    <= 1'b0;
                    r_clk_out <= 1'b0;
                    // pending equals active whenever nothing is waiting.
                    r_active  <= r_pending;
                    r_pend    <= w_wr;
                    if (w_wr) begin
                        r_pending <= wr_div;
                    end
                end else begin
                    if (w_sync) begin
                        r_count   <= '0;
                        r_tick    <= 1'b0;
                        r_clk_out <= 1'b0;
                    end else if (w_tc) begin
                        r_count   <= '0;
                        r_tick    <= 1'b1;
                        r_clk_out <= ~r_clk_out;
                    end else begin
                        r_count   <= r_count + WIDTH'(1);
                        r_tick    <= 1'b0;
                    end

                    // A write landing on the apply edge supersedes the older pending value.
                    if (w_apply) begin
                        if (w_wr) begin
                            r_active  <= wr_div;
                            r_pending <= wr_div;
                        end else begin
                            r_active  <= r_pending;
                        end
                        r_pend <= 1'b0;
                    end else if (w_wr) begin
                        r_pending <= wr_div;
                        r_pend    <= 1'b1;
                    end
                end
            end

            assign clk_out[g] = r_clk_out;
            assign tick[g]    = r_tick;
            assign pend[g]    = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_divider_multi
// Brief    : Self-checking bench for clk_divider_multi: vector table, directed
//            timing sequences and randomized traffic against a period model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_divider_multi;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic          clk;
    logic          rst;
    logic [NCH-1:0] en;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [W-1:0]  wr_div;
`ifdef CLK_DIV_SYNC_EN
    logic          sync_i;
`endif
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int n_cmp = 0;
    int n_err = 0;

    clk_divider_multi #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(49999)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
`ifdef CLK_DIV_SYNC_EN
        .sync_i  (sync_i),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Period model: position within the current period, divisor in force,
    // queued divisor, and the phase of the half-rate output.
    int m_pos [NCH];
    int m_act [NCH];
    int m_pnd [NCH];
    bit m_pend[NCH];
    bit m_out [NCH];
    bit m_tick[NCH];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit sy;
        bit hit;
        bit done;
        sy = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        sy = sync_i;
`endif
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_pos[c] = 0; m_act[c] = 49999; m_pnd[c] = 49999;
                m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                continue;
            end
            hit = wr_en && (int'(wr_ch) == c);
            if (!en[c]) begin
                m_pos[c] = 0; m_tick[c] = 0; m_out[c] = 0;
                if (m_pend[c]) m_act[c] = m_pnd[c];
                m_pend[c] = 0;
                if (hit) begin m_pnd[c] = int'(wr_div); m_pend[c] = 1; end
            end else begin
                done = !sy && (m_pos[c] == m_act[c]);
                if (sy) begin
                    m_pos[c] = 0; m_tick[c] = 0; m_out[c] = 0;
                end else if (done) begin
                    m_pos[c] = 0; m_tick[c] = 1; m_out[c] = !m_out[c];
                end else begin
                    m_pos[c]++; m_tick[c] = 0;
                end
                if (sy || done) begin
                    if (hit) begin
                        m_act[c] = int'(wr_div); m_pnd[c] = int'(wr_div);
                    end else if (m_pend[c]) begin
                        m_act[c] = m_pnd[c];
                    end
                    m_pend[c] = 0;
                end else if (hit) begin
                    m_pnd[c] = int'(wr_div); m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic step();
        int vo, vt, vp;
        @(posedge clk);
        model_edge();
        #1;
        vo = 0; vt = 0; vp = 0;
        for (int c = 0; c < NCH; c++) begin
            vo |= int'(m_out[c]) << c;
            vt |= int'(m_tick[c]) << c;
            vp |= int'(m_pend[c]) << c;
        end
        chk("model_clk_out", int'(clk_out), vo);
        chk("model_tick", int'(tick), vt);
        chk("model_pend", int'(pend), vp);
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 4'(ch); wr_div = W'(d);
        step();
        wr_en = 1'b0;
    endtask

    // Edges from now until tick[ch] is first observed high.
    task automatic wait_tick(input int ch, input int bound, input string name, input int exp);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < bound) begin
            step();
            n++;
            seen = tick[ch];
        end
        if (!seen) n = -1;
        chk(name, n, exp);
    endtask

    typedef struct {
        logic [3:0]  en;
        logic        wr_en;
        logic [3:0]  wr_ch;
        logic [15:0] wr_div;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int first, nt, bad, prev, run, minrun, t0, t1;
        bit started;

        tbl[0]  = '{4'b0000, 1'b1, 4'd0, 16'd1, 4'b0000, 4'b0000, 4'b0001};
        tbl[1]  = '{4'b0000, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b0001, 1'b1, 4'd4, 16'd7, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0001, 1'b1, 4'd0, 16'd2, 4'b0001, 4'b0001, 4'b0000};
        tbl[8]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0001, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000};
        tbl[11] = '{4'b0000, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 1'b1, 4'd2, 16'd0, 4'b0000, 4'b0000, 4'b0100};
        tbl[13] = '{4'b0000, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0100, 1'b0, 4'd0, 16'd0, 4'b0100, 4'b0100, 4'b0000};
        tbl[15] = '{4'b0100, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0100, 4'b0000};
        tbl[16] = '{4'b0000, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};

        rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
`ifdef CLK_DIV_SYNC_EN
        sync_i = 1'b0;
`endif

        // Reset and idle
        step(); step();
        rst = 1'b0;
        step();
        chk("idle_clk_out", int'(clk_out), 0);
        chk("idle_tick", int'(tick), 0);
        chk("idle_pend", int'(pend), 0);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; wr_en = tbl[i].wr_en; wr_ch = tbl[i].wr_ch; wr_div = tbl[i].wr_div;
            step();
            wr_en = 1'b0;
            chk($sformatf("tbl%0d_clk_out", i), int'(clk_out), int'(tbl[i].exp_clk));
            chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].exp_tick));
            chk($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].exp_pend));
        end

        // Basic divide, D=3 on ch0
        write(0, 3);
        step();
        en[0] = 1'b1;
        first = -1; nt = 0; bad = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (tick[0]) begin nt++; if (first < 0) first = i; end
            if (clk_out[0] !== 1'(((i / 4) % 2))) bad++;
            if (tick[0] !== (i % 4 == 0)) bad++;
        end
        chk("d3_first_tick", first, 4);
        chk("d3_tick_count", nt, 6);
        chk("d3_pattern_errors", bad, 0);

        // Write landing exactly on ch0's terminal count
        step(); step(); step();
        write(0, 5);
        chk("tcwrite_tick", int'(tick[0]), 1);
        chk("tcwrite_pend", int'(pend[0]), 0);
        wait_tick(0, 20, "tcwrite_next_period", 6);

        // Glitch-free reload on ch1: D=9 then D=2 mid-period
        write(1, 9);
        step();
        en[1] = 1'b1;
        wait_tick(1, 30, "reload_first_tick", 10);
        step(); step(); step(); step();
        write(1, 2);
        chk("reload_pend_set", int'(pend[1]), 1);
        wait_tick(1, 30, "reload_old_period_rest", 5);
        chk("reload_pend_clear", int'(pend[1]), 0);
        wait_tick(1, 30, "reload_new_period_a", 3);
        wait_tick(1, 30, "reload_new_period_b", 3);
        prev = int'(clk_out[1]); run = 0; minrun = 1000; started = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (int'(clk_out[1]) == prev) run++;
            else begin
                if (started && run < minrun) minrun = run;
                started = 1'b1; run = 1; prev = int'(clk_out[1]);
            end
        end
        chk("reload_min_half_period", minrun, 3);

        // D=0 on ch2: tick every cycle, clk/2
        write(2, 0);
        step();
        en[2] = 1'b1;
        bad = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (tick[2] !== 1'b1) bad++;
            if (clk_out[2] !== 1'(i % 2)) bad++;
        end
        chk("d0_pattern_errors", bad, 0);

        // Writes to non-existent channels
        en = '0;
        step(); step();
        wr_en = 1'b1; wr_ch = 4'd4; wr_div = 16'd1;
        step();
        chk("badch4_pend", int'(pend), 0);
        chk("badch4_clk_out", int'(clk_out), 0);
        wr_ch = 4'd15;
        step();
        wr_en = 1'b0;
        chk("badch15_pend", int'(pend), 0);
        en[0] = 1'b1;
        wait_tick(0, 20, "badch_ch0_unchanged", 6);

        // Disable ch3 with a divisor pending
        en[3] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        write(3, 6);
        chk("dis_pend_before", int'(pend[3]), 1);
        en[3] = 1'b0;
        step();
        chk("dis_clk_out", int'(clk_out[3]), 0);
        chk("dis_pend_applied", int'(pend[3]), 0);
        en[3] = 1'b1;
        wait_tick(3, 20, "dis_new_div_used", 7);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 31) == 0) en[c] = ~en[c];
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_ch  = 4'($urandom_range(0, 5));
            wr_div = W'($urandom_range(0, 12));
`ifdef CLK_DIV_SYNC_EN
            sync_i = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        wr_en = 1'b0; en = '0;
`ifdef CLK_DIV_SYNC_EN
        sync_i = 1'b0;
`endif
        step(); step();

`ifdef CLK_DIV_SYNC_EN
        // Phase alignment of ch0 (D=4) and ch1 (D=6)
        write(0, 4);
        write(1, 6);
        step();
        en[0] = 1'b1;
        step(); step(); step();
        en[1] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        chk("sync_clk_out", int'(clk_out[1:0]), 0);
        chk("sync_tick", int'(tick[1:0]), 0);
        t0 = -1; t1 = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (tick[0] && t0 < 0) t0 = i;
            if (tick[1] && t1 < 0) t1 = i;
        end
        chk("sync_ch0_first_tick", t0, 5);
        chk("sync_ch1_first_tick", t1, 7);
        en = '0;
        step(); step();
`endif

        // Reset mid-operation restores the default divisor
        en = 4'b0011;
        step(); step(); step();
        write(1, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pend", int'(pend), 0);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        en = 4'b0001;
        wait_tick(0, 60000, "rst_default_div_period", 50000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed divide-by-N toggle divider.
- Each channel derives, from the one system clock, a 50%-duty toggle output and a one-cycle tick strobe.
- Each channel's divisor is loaded at runtime and takes effect glitch-free at the channel's next terminal count.
- Used for display refresh, debounce sampling and LED blink rates, replacing several hard-coded divider instances.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 16, counter and divisor width in bits.
- DEFAULT_DIV, 49999, reset value of every channel's active and pending divisor. Must fit in WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- wr_en  input  1  divisor write strobe; one write per cycle.
- wr_ch  input  4  target channel index for the write.
- wr_div  input  WIDTH  divisor value D to load.
- clk_out  output  NUM_CH  per-channel toggle output; registered.
- tick  output  NUM_CH  per-channel one-cycle terminal-count strobe; registered.
- pend  output  NUM_CH  high while a written divisor is waiting to be applied.
- sync_i  input  1  present only with CLK_DIV_SYNC_EN; see Optional Feature.

Behaviour:
- Reset: sampled on the clk edge only. Sets for all channels: count=0, active_div=DEFAULT_DIV, pending_div=DEFAULT_DIV, clk_out=0, tick=0, pend=0. Reset mid-operation aborts any pending write.
- Terminal count (per channel): tc = en[ch] && (count == active_div).
- Enabled channel, each edge:
  - if tc: count<=0, tick<=1, clk_out<=~clk_out;
  - else: count<=count+1, tick<=0.
- Timing for divisor D:
  - tick period = D+1 cycles.
  - clk_out period = 2(D+1) cycles, 50% duty.
  - After en rises with count=0, the first tick is high in the cycle after the (D+1)th edge.
- D=0: tick high every cycle; clk_out toggles every cycle (clk/2).
- Disabled channel (en[ch]=0), each edge: count<=0, tick<=0, clk_out<=0. Any pending divisor is applied immediately: active<=pending, pend<=0.
- Re-enable: the channel restarts from count=0 with clk_out=0.
- Write (wr_en=1 and wr_ch<NUM_CH): pending_div[wr_ch]<=wr_div and pend[wr_ch]<=1.
- Write with wr_ch>=NUM_CH: ignored, no state change.
- Apply: on a tc edge with pend=1, active_div<=pending_div and pend<=0. The current period always completes at the old divisor. No runt pulses on clk_out.
- Write and tc on the same channel in the same edge: wr_div goes directly to active_div and pend ends at 0. The write wins over the older pending value.
- Second write before apply: overwrites pending_div. Only the last value is applied.
- Arithmetic: count is unsigned WIDTH bits. Because count never exceeds active_div, no wrap-around is reachable.
- Channels are fully independent apart from the shared write port.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds input sync_i.
  - On an edge with sync_i=1: every enabled channel sets count<=0, clk_out<=0, tick<=0. This phase-aligns all channels.
  - Pending divisors are applied on that edge, as at tc.
  - Reset has priority over sync_i, and sync_i has priority over tc.
- Undefined:
  - The sync_i port does not exist.
  - Channels free-run and realign only via en or rst.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release with en=0 → clk_out=0, tick=0, pend=0 on every channel; count holds at 0.
- Basic divide: write ch0 D=3 while en[0]=0, then set en[0]=1 → tick[0] is high 1 cycle in every 4; clk_out[0] has period 8 with 4 high / 4 low; first tick in the cycle after the 4th edge.
- Glitch-free reload: ch1 running at D=9; write D=2 mid-period → pend[1]=1 until the next tc; the current period stays 10 cycles; subsequent ticks are every 3 cycles; no clk_out pulse shorter than 3 cycles.
- Boundaries:
  - D=0 on ch2 → tick[2] stays high and clk_out[2] toggles every cycle.
  - Write with wr_ch=NUM_CH → no output or pend change on any channel.
  - Write coinciding with ch0's tc → the new D is used from the next period and pend[0] stays 0.
- Disable/reset mid-operation: deassert en[3] mid-count → clk_out[3]=0 the next cycle and a pending divisor is applied with pend[3]=0. Assert rst mid-count → all active divisors return to DEFAULT_DIV (49999).
- CLK_DIV_SYNC_EN build: ch0 D=4 and ch1 D=6 running out of phase; pulse sync_i for 1 cycle → both clk_out go to 0, and the next tick[0] and tick[1] arrive 5 and 7 cycles later respectively.
